// File: rtl/nthband_predictor_scheduler_if.sv
// Operand and result streams of the nth-band predictor scheduler.
// The scheduler takes the slave view; whoever feeds and drains it takes the master view.
interface nthband_predictor_scheduler_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int ALPHA_WIDTH = 10
);
  logic                   param_valid;
  logic                   param_ready;
  logic [ALPHA_WIDTH-1:0] param_alpha;
  logic [DATA_WIDTH-1:0]  param_xmean;
  logic [DATA_WIDTH-1:0]  param_xhatmean;

  logic                   xhat_valid;
  logic                   xhat_ready;
  logic [DATA_WIDTH-1:0]  xhat_data;

  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_xhat;
  logic [ALPHA_WIDTH-1:0] out_alpha;
  logic [DATA_WIDTH-1:0]  out_xmean;
  logic [DATA_WIDTH-1:0]  out_xhatmean;
  logic                   out_last;

  modport master (
    output param_valid, param_alpha, param_xmean, param_xhatmean,
    output xhat_valid, xhat_data,
    output out_ready,
    input  param_ready, xhat_ready,
    input  out_valid, out_xhat, out_alpha, out_xmean, out_xhatmean, out_last
  );

  modport slave (
    input  param_valid, param_alpha, param_xmean, param_xhatmean,
    input  xhat_valid, xhat_data,
    input  out_ready,
    output param_ready, xhat_ready,
    output out_valid, out_xhat, out_alpha, out_xmean, out_xhatmean, out_last
  );
endinterface

// File: rtl/nthband_predictor_scheduler.sv
// Joins one per-block parameter set with each of the 2^BLOCK_SIZE_LOG xhat samples of
// that block and presents them as a single registered beat, flagging the block's last sample.
module nthband_predictor_scheduler #(
  parameter int DATA_WIDTH     = 16,
  parameter int ALPHA_WIDTH    = 10,
  parameter int BLOCK_SIZE_LOG = 8
) (
  input logic                        clk,
  input logic                        rst,
  nthband_predictor_scheduler_if.slave bus
);

  localparam int CNT_W = (BLOCK_SIZE_LOG == 0) ? 1 : BLOCK_SIZE_LOG;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((64'd1 << BLOCK_SIZE_LOG) - 64'd1);

  typedef enum logic {
    WAIT_PARAM,
    STREAM
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CNT_W-1:0]       cnt_q;
  logic [ALPHA_WIDTH-1:0] alpha_q;
  logic [DATA_WIDTH-1:0]  xmean_q;
  logic [DATA_WIDTH-1:0]  xhatmean_q;

  logic                   out_valid_q;
  logic [DATA_WIDTH-1:0]  out_xhat_q;
  logic [ALPHA_WIDTH-1:0] out_alpha_q;
  logic [DATA_WIDTH-1:0]  out_xmean_q;
  logic [DATA_WIDTH-1:0]  out_xhatmean_q;
  logic                   out_last_q;

  logic param_ready;
  logic xhat_ready;
  logic param_fire;
  logic xhat_fire;
  logic last_sample;

  assign param_fire  = bus.param_valid && param_ready;
  assign xhat_fire   = bus.xhat_valid && xhat_ready;
  assign last_sample = (cnt_q == LAST_CNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WAIT_PARAM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_PARAM: if (param_fire) state_d = STREAM;
      STREAM:     if (xhat_fire && last_sample) state_d = WAIT_PARAM;
      default:    state_d = WAIT_PARAM;
    endcase
  end

  // Readies depend only on state and the output register, never on the incoming valids.
  always_comb begin
    param_ready = 1'b0;
    xhat_ready  = 1'b0;
    case (state_q)
      WAIT_PARAM: param_ready = 1'b1;
      STREAM:     xhat_ready  = !out_valid_q || bus.out_ready;
      default:    param_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alpha_q    <= '0;
      xmean_q    <= '0;
      xhatmean_q <= '0;
      cnt_q      <= '0;
    end else if (param_fire) begin
      alpha_q    <= bus.param_alpha;
      xmean_q    <= bus.param_xmean;
      xhatmean_q <= bus.param_xhatmean;
      cnt_q      <= '0;
    end else if (xhat_fire) begin
      cnt_q      <= last_sample ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Params are copied into the beat at load time, so the param regs are free to take the
  // next block's set while the final beat of this block is still stalled downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_xhat_q     <= '0;
      out_alpha_q    <= '0;
      out_xmean_q    <= '0;
      out_xhatmean_q <= '0;
      out_last_q     <= 1'b0;
    end else if (xhat_fire) begin
      out_valid_q    <= 1'b1;
      out_xhat_q     <= bus.xhat_data;
      out_alpha_q    <= alpha_q;
      out_xmean_q    <= xmean_q;
      out_xhatmean_q <= xhatmean_q;
      out_last_q     <= last_sample;
    end else if (bus.out_ready) begin
      out_valid_q    <= 1'b0;
    end
  end

  assign bus.param_ready  = param_ready;
  assign bus.xhat_ready   = xhat_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_xhat     = out_xhat_q;
  assign bus.out_alpha    = out_alpha_q;
  assign bus.out_xmean    = out_xmean_q;
  assign bus.out_xhatmean = out_xhatmean_q;
  assign bus.out_last     = out_last_q;

endmodule

// File: tb/tb_nthband_predictor_scheduler.sv
// Randomised bench for nthband_predictor_scheduler: a stream-level model pairs every accepted
// sample with its block's parameters and is compared against each output beat.
module tb_nthband_predictor_scheduler;

  localparam int DW  = 16;
  localparam int AW  = 10;
  localparam int BSL = 2;
  localparam int N   = 1 << BSL;

  typedef struct {
    logic [AW-1:0] alpha;
    logic [DW-1:0] xmean;
    logic [DW-1:0] xhatmean;
  } par_t;

  typedef struct {
    logic [DW-1:0] xhat;
    logic [AW-1:0] alpha;
    logic [DW-1:0] xmean;
    logic [DW-1:0] xhatmean;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nthband_predictor_scheduler_if #(.DATA_WIDTH(DW), .ALPHA_WIDTH(AW)) bus ();
  nthband_predictor_scheduler_if #(.DATA_WIDTH(DW), .ALPHA_WIDTH(AW)) bus0 ();

  nthband_predictor_scheduler #(.DATA_WIDTH(DW), .ALPHA_WIDTH(AW), .BLOCK_SIZE_LOG(BSL)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  nthband_predictor_scheduler #(.DATA_WIDTH(DW), .ALPHA_WIDTH(AW), .BLOCK_SIZE_LOG(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );

  int checks = 0;
  int errors = 0;

  par_t          par_q[$];
  logic [DW-1:0] xh_q[$];
  par_t          acc_par[$];
  beat_t         exp_q[$];
  beat_t         log_q[$];

  int cyc = 0;
  int n_p = 0;
  int n_x = 0;
  bit p_fire = 0;
  bit x_fire = 0;
  bit pend_v = 0;
  logic [DW-1:0] pend_x;
  bit stall_v = 0;
  logic [63:0] stall_snap;
  bit gap_en = 0;
  int prev_cyc = -1;
  bit prev_last = 0;
  bit log_en = 0;
  int valid_mode = 0;
  int ready_mode = 0;
  int rc = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  function automatic logic [63:0] pack(input beat_t b);
    return {5'd0, b.xhat, b.alpha, b.xmean, b.xhatmean, b.last};
  endfunction

  function automatic logic [63:0] pack_out();
    return {5'd0, bus.out_xhat, bus.out_alpha, bus.out_xmean, bus.out_xhatmean, bus.out_last};
  endfunction

  function automatic beat_t out_beat();
    beat_t b;
    b.xhat     = bus.out_xhat;
    b.alpha    = bus.out_alpha;
    b.xmean    = bus.out_xmean;
    b.xhatmean = bus.out_xhatmean;
    b.last     = bus.out_last;
    return b;
  endfunction

  // Stream-level model: sample k belongs to block k/N and is last when k%N == N-1.
  initial begin
    beat_t e;
    par_t  p;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        exp_q.delete();
        acc_par.delete();
        n_p = 0;
        n_x = 0;
        pend_v = 0;
        stall_v = 0;
        p_fire = 0;
        x_fire = 0;
        checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
      end else begin
        if (pend_v) begin
          checkOutput("latency_valid", {63'd0, bus.out_valid}, 64'd1);
          checkOutput("latency_xhat", {48'd0, bus.out_xhat}, {48'd0, pend_x});
        end
        if (stall_v) begin
          checkOutput("stall_valid", {63'd0, bus.out_valid}, 64'd1);
          checkOutput("stall_hold", pack_out(), stall_snap);
        end
        stall_v = bus.out_valid && !bus.out_ready;
        if (stall_v) begin
          stall_snap = pack_out();
          checkOutput("stall_xhat_ready", {63'd0, bus.xhat_ready}, 64'd0);
        end
        if (bus.out_valid && bus.out_ready) begin
          checkOutput("beat_expected", {63'd0, exp_q.size() > 0}, 64'd1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("beat", pack_out(), pack(e));
          end
          if (log_en) log_q.push_back(out_beat());
          if (gap_en) begin
            if (prev_cyc >= 0) checkOutput("beat_spacing", 64'(cyc - prev_cyc), prev_last ? 64'd2 : 64'd1);
            prev_cyc  = cyc;
            prev_last = bus.out_last;
          end
        end
        p_fire = bus.param_valid && bus.param_ready;
        x_fire = bus.xhat_valid && bus.xhat_ready;
        if (p_fire) begin
          checkOutput("param_gate", 64'(n_x), 64'(n_p * N));
          p.alpha    = bus.param_alpha;
          p.xmean    = bus.param_xmean;
          p.xhatmean = bus.param_xhatmean;
          acc_par.push_back(p);
          n_p++;
        end
        pend_v = x_fire;
        if (x_fire) begin
          checkOutput("xhat_gate", {63'd0, n_x < n_p * N}, 64'd1);
          e.xhat = bus.xhat_data;
          if (n_x / N < acc_par.size()) begin
            e.alpha    = acc_par[n_x / N].alpha;
            e.xmean    = acc_par[n_x / N].xmean;
            e.xhatmean = acc_par[n_x / N].xhatmean;
          end else begin
            e.alpha = '0; e.xmean = '0; e.xhatmean = '0;
          end
          e.last = ((n_x % N) == N - 1);
          exp_q.push_back(e);
          pend_x = bus.xhat_data;
          n_x++;
        end
      end
    end
  end

  // Source/sink driver: valids never look at ready; data held until the handshake.
  initial begin
    bus.param_valid = 0; bus.param_alpha = '0; bus.param_xmean = '0; bus.param_xhatmean = '0;
    bus.xhat_valid = 0; bus.xhat_data = '0; bus.out_ready = 0;
    bus0.param_valid = 0; bus0.param_alpha = '0; bus0.param_xmean = '0; bus0.param_xhatmean = '0;
    bus0.xhat_valid = 0; bus0.xhat_data = '0; bus0.out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (p_fire && par_q.size() > 0) void'(par_q.pop_front());
      if (x_fire && xh_q.size() > 0) void'(xh_q.pop_front());
      if (!bus.param_valid || p_fire) begin
        if (par_q.size() > 0 && (valid_mode == 0 || $urandom_range(0, 2) != 0)) begin
          bus.param_valid    = 1;
          bus.param_alpha    = par_q[0].alpha;
          bus.param_xmean    = par_q[0].xmean;
          bus.param_xhatmean = par_q[0].xhatmean;
        end else begin
          bus.param_valid = 0;
        end
      end
      if (!bus.xhat_valid || x_fire) begin
        if (xh_q.size() > 0 && (valid_mode == 0 || $urandom_range(0, 2) != 0)) begin
          bus.xhat_valid = 1;
          bus.xhat_data  = xh_q[0];
        end else begin
          bus.xhat_valid = 0;
        end
      end
      rc++;
      case (ready_mode)
        0:       bus.out_ready = 1;
        1:       bus.out_ready = ($urandom_range(0, 1) == 1);
        default: bus.out_ready = ((rc % 20) >= 9 && (rc % 20) <= 13) ? 1'b0 : ((rc % 2) == 0);
      endcase
    end
  end

  task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] xm, input logic [DW-1:0] xhm,
                               input logic [DW-1:0] x0, input int step);
    par_t p;
    p.alpha = a; p.xmean = xm; p.xhatmean = xhm;
    par_q.push_back(p);
    for (int i = 0; i < N; i++) begin
      if (step < 0) xh_q.push_back(DW'($urandom));
      else          xh_q.push_back(x0 + DW'(i * step));
    end
  endtask

  task automatic apply_random_block();
    applyStimulus(AW'($urandom), DW'($urandom), DW'($urandom), '0, -1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (n < budget && !(par_q.size() == 0 && xh_q.size() == 0 && exp_q.size() == 0 &&
                           !bus.out_valid && !bus.param_valid && !bus.xhat_valid)) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput(name, {63'd0, n < budget}, 64'd1);
  endtask

  task automatic check_reset_state(input string tag);
    checkOutput({tag, "_param_ready"}, {63'd0, bus.param_ready}, 64'd1);
    checkOutput({tag, "_xhat_ready"}, {63'd0, bus.xhat_ready}, 64'd0);
    checkOutput({tag, "_out_valid"}, {63'd0, bus.out_valid}, 64'd0);
    checkOutput({tag, "_out_regs"}, pack_out(), 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst = 1;
    par_q.delete();
    xh_q.delete();
    bus.param_valid = 0;
    bus.xhat_valid  = 0;
    #1;
    check_reset_state("async_reset");
    repeat (2) @(posedge clk);
    #2;
    rst = 0;
  endtask

  task automatic run_bsl0();
    int pa[3] = '{5, 6, 7};
    int pm[3] = '{100, 110, 120};
    int ph[3] = '{200, 210, 220};
    int xs[3] = '{11, 22, 33};
    int pi = 0;
    int xi = 0;
    int k  = 0;
    for (int c = 0; c < 40 && k < 3; c++) begin
      @(posedge clk); #1;
      bus0.out_ready      = 1;
      bus0.param_valid    = (pi < 3);
      bus0.param_alpha    = AW'(pa[pi < 3 ? pi : 0]);
      bus0.param_xmean    = DW'(pm[pi < 3 ? pi : 0]);
      bus0.param_xhatmean = DW'(ph[pi < 3 ? pi : 0]);
      bus0.xhat_valid     = (xi < 3);
      bus0.xhat_data      = DW'(xs[xi < 3 ? xi : 0]);
      @(negedge clk);
      if (bus0.out_valid) begin
        checkOutput("bsl0_xhat", {48'd0, bus0.out_xhat}, 64'(xs[k]));
        checkOutput("bsl0_alpha", {54'd0, bus0.out_alpha}, 64'(pa[k]));
        checkOutput("bsl0_xmean", {48'd0, bus0.out_xmean}, 64'(pm[k]));
        checkOutput("bsl0_xhatmean", {48'd0, bus0.out_xhatmean}, 64'(ph[k]));
        checkOutput("bsl0_last", {63'd0, bus0.out_last}, 64'd1);
        k++;
      end
      if (bus0.param_valid && bus0.param_ready) pi++;
      if (bus0.xhat_valid && bus0.xhat_ready) xi++;
    end
    checkOutput("bsl0_beat_count", 64'(k), 64'd3);
  endtask

  initial begin
    int wait_n;
    repeat (3) @(posedge clk);
    #2;
    rst = 0;
    @(negedge clk); #1;
    check_reset_state("reset_release");

    // Single hand-computed block.
    valid_mode = 0; ready_mode = 0;
    log_q.delete(); log_en = 1;
    applyStimulus(10'd3, 16'd640, 16'd384, 16'd256, 2);
    wait_drain("drain_block", 200);
    log_en = 0;
    checkOutput("blk_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      checkOutput("blk_first_xhat", {48'd0, log_q[0].xhat}, 64'd256);
      checkOutput("blk_last_xhat", {48'd0, log_q[3].xhat}, 64'd262);
      checkOutput("blk_alpha", {54'd0, log_q[1].alpha}, 64'd3);
      checkOutput("blk_xmean", {48'd0, log_q[2].xmean}, 64'd640);
      checkOutput("blk_xhatmean", {48'd0, log_q[3].xhatmean}, 64'd384);
      checkOutput("blk_not_last", {63'd0, log_q[2].last}, 64'd0);
      checkOutput("blk_last", {63'd0, log_q[3].last}, 64'd1);
    end

    // Back-to-back blocks with always-valid sources: one idle cycle per boundary.
    prev_cyc = -1; gap_en = 1;
    applyStimulus(10'd17, 16'd1000, 16'd2000, 16'd300, 1);
    applyStimulus(10'd99, 16'd3000, 16'd4000, 16'd500, 3);
    wait_drain("drain_b2b", 200);
    gap_en = 0;

    // Toggling backpressure with a five-cycle stall mid-block.
    ready_mode = 2;
    for (int b = 0; b < 4; b++) apply_random_block();
    wait_drain("drain_toggle", 400);

    // Randomised sources and sink.
    valid_mode = 1; ready_mode = 1;
    for (int b = 0; b < 25; b++) apply_random_block();
    wait_drain("drain_random", 3000);

    // Reset mid-block, then a fresh block whose samples arrive before its parameters.
    valid_mode = 0; ready_mode = 0;
    applyStimulus(10'd1, 16'd2, 16'd3, 16'd40, 1);
    wait_n = 0;
    while (n_x < 2 && wait_n < 50) begin @(negedge clk); wait_n++; end
    checkOutput("mid_block_reached", {63'd0, n_x >= 2}, 64'd1);
    pulse_reset();
    log_q.delete(); log_en = 1;
    for (int i = 0; i < N; i++) xh_q.push_back(DW'(16'h0A00 + i));
    repeat (5) @(negedge clk);
    #1;
    checkOutput("xhat_waits_for_param", 64'(n_x), 64'd0);
    checkOutput("xhat_ready_in_wait", {63'd0, bus.xhat_ready}, 64'd0);
    begin
      par_t p;
      p.alpha = 10'd77; p.xmean = 16'd7000; p.xhatmean = 16'd7100;
      par_q.push_back(p);
    end
    wait_drain("drain_after_reset", 200);
    log_en = 0;
    checkOutput("post_reset_count", 64'(log_q.size()), 64'd4);
    if (log_q.size() == 4) begin
      checkOutput("post_reset_third_not_last", {63'd0, log_q[2].last}, 64'd0);
      checkOutput("post_reset_fourth_last", {63'd0, log_q[3].last}, 64'd1);
      checkOutput("post_reset_alpha", {54'd0, log_q[0].alpha}, 64'd77);
      checkOutput("post_reset_first_xhat", {48'd0, log_q[0].xhat}, 64'h0A00);
    end

    run_bsl0();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
